// File: rtl/survivor_mem_arbiter.sv
// survivor_mem_arbiter: shares one single-port survivor RAM between the ACS writer and traceback reader.
// Optional build macro SURV_MEM_RR_EN selects round-robin arbitration instead of write priority with starvation escape.
`default_nettype none

module survivor_mem_arbiter #(
  parameter int DATA_W     = 4,
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 6,
  parameter int STARVE_MAX = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              frame_done
);

  typedef enum logic [0:0] {FILL = 1'b0, RUN = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic              frame_done_q;
  logic              rd_valid_q;
  logic              wr_gnt;
  logic              rd_gnt;

`ifdef SURV_MEM_RR_EN
  logic last_rd_q;  // 1 = read was granted last; reset value hands the first conflict to the writer
`else
  localparam int SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  logic [SC_W-1:0] starve_q;
`endif

  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (!RST && !flush) begin
      if (state_q == FILL) begin
        wr_gnt = wr_req;
      end else begin
`ifdef SURV_MEM_RR_EN
        if (wr_req && rd_req) begin
          wr_gnt = last_rd_q;
          rd_gnt = !last_rd_q;
        end else begin
          wr_gnt = wr_req;
          rd_gnt = rd_req;
        end
`else
        if (rd_req && (starve_q == SC_W'(STARVE_MAX))) begin
          rd_gnt = 1'b1;
        end else begin
          wr_gnt = wr_req;
          rd_gnt = rd_req && !wr_req;
        end
`endif
      end
    end
  end

  assign wr_ready   = wr_gnt;
  assign rd_ready   = rd_gnt;
  assign mem_en     = wr_gnt | rd_gnt;
  assign mem_we     = wr_gnt;
  assign mem_addr   = wr_gnt ? wr_ptr_q : (rd_gnt ? rd_addr : '0);
  assign mem_wdata  = wr_gnt ? wr_data : '0;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = RST ? '0 : mem_rdata;
  assign wr_ptr     = wr_ptr_q;
  assign frame_done = frame_done_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= FILL;
      wr_ptr_q     <= '0;
      frame_done_q <= 1'b0;
      rd_valid_q   <= 1'b0;
`ifdef SURV_MEM_RR_EN
      last_rd_q    <= 1'b1;
`else
      starve_q     <= '0;
`endif
    end else begin
      rd_valid_q   <= rd_gnt;
      frame_done_q <= wr_gnt && (wr_ptr_q == LAST_ADDR);
      if (flush) begin
        state_q   <= FILL;
        wr_ptr_q  <= '0;
`ifdef SURV_MEM_RR_EN
        last_rd_q <= 1'b1;
`else
        starve_q  <= '0;
`endif
      end else begin
        if (wr_gnt)
          wr_ptr_q <= (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + ADDR_W'(1);
        if (state_q == FILL && wr_gnt && wr_ptr_q == LAST_ADDR)
          state_q <= RUN;
`ifdef SURV_MEM_RR_EN
        if (state_q == RUN && (wr_gnt || rd_gnt))
          last_rd_q <= rd_gnt;
`else
        // Only denials in RUN age the read; FILL denials are by design, not contention.
        if (rd_gnt || state_q == FILL)
          starve_q <= '0;
        else if (rd_req)
          starve_q <= starve_q + SC_W'(1);
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_survivor_mem_arbiter.sv
// tb_survivor_mem_arbiter: directed checks of survivor_mem_arbiter in its default (write-priority) build.
`default_nettype none

module tb_survivor_mem_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       flush;
  logic       wr_req;
  logic [3:0] wr_data;
  logic       wr_ready;
  logic       rd_req;
  logic [5:0] rd_addr;
  logic       rd_ready;
  logic       rd_valid;
  logic [3:0] rd_data;
  logic       mem_en;
  logic       mem_we;
  logic [5:0] mem_addr;
  logic [3:0] mem_wdata;
  logic [3:0] mem_rdata;
  logic [5:0] wr_ptr;
  logic       frame_done;

  int total = 0;
  int bad   = 0;

  logic [3:0] ram [64];

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  survivor_mem_arbiter #(
    .DATA_W(4), .DEPTH(64), .ADDR_W(6), .STARVE_MAX(3)
  ) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wr_ptr(wr_ptr), .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int         wptr;
    logic       rsel;
    RST = 1'b1; flush = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    wr_data = 4'h0; rd_addr = 6'd0;

    // Reset holds every output at 0 even with both requests asserted
    @(negedge CLK);
    wr_req = 1'b1; rd_req = 1'b1; rd_addr = 6'd9; wr_data = 4'h7;
    #1;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_mem_en",   mem_en,   0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wdata",    mem_wdata, 0);
    chk("rst_wr_ptr",   wr_ptr,   0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_fdone",    frame_done, 0);

    @(negedge CLK);
    RST = 1'b0; wr_req = 1'b0; rd_req = 1'b0;

    // Fill one frame; from write 10 on a read is also requested and must be refused
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK);
      wr_req = 1'b1; wr_data = 4'(i); rd_req = (i >= 10); rd_addr = 6'd9;
      #1;
      chk("fill_wr_ready", wr_ready, 1);
      chk("fill_mem_we",   mem_we,   1);
      chk("fill_addr",     mem_addr, 32'(i));
      chk("fill_wdata",    mem_wdata, 32'(i % 16));
      chk("fill_wr_ptr",   wr_ptr,   32'(i));
      chk("fill_rd_ready", rd_ready, 0);
      chk("fill_fdone",    frame_done, 0);
    end

    // Idle cycle: wrap seen, frame_done pulse, bus idles to 0
    @(negedge CLK);
    wr_req = 1'b0; rd_req = 1'b0; wr_data = 4'hF; rd_addr = 6'd7;
    #1;
    chk("wrap_wr_ptr",  wr_ptr, 0);
    chk("wrap_fdone",   frame_done, 1);
    chk("idle_mem_en",  mem_en, 0);
    chk("idle_addr",    mem_addr, 0);
    chk("idle_wdata",   mem_wdata, 0);

    // RUN contention: W W W R W W W R; second read sees the overwrite of address 5
    wptr = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      wr_req = 1'b1; rd_req = 1'b1; rd_addr = 6'd5; wr_data = 4'hC;
      #1;
      rsel = ((k % 4) == 3);
      chk("run_wr_ready", wr_ready, 32'(!rsel));
      chk("run_rd_ready", rd_ready, 32'(rsel));
      chk("run_mem_we",   mem_we,   32'(!rsel));
      chk("run_mem_en",   mem_en,   1);
      chk("run_addr",     mem_addr, rsel ? 32'd5 : 32'(wptr));
      chk("run_wr_ptr",   wr_ptr,   32'(wptr));
      chk("run_rd_valid", rd_valid, 32'(k == 4));
      if (k == 0) chk("run_fdone_clr", frame_done, 0);
      if (k == 4) chk("run_rd_data", rd_data, 5);
      if (!rsel) wptr++;
    end

    // Flush right after a read grant: pending rd_valid still fires, nothing granted
    @(negedge CLK);
    flush = 1'b1;
    #1;
    chk("fl_rd_valid", rd_valid, 1);
    chk("fl_rd_data",  rd_data,  4'hC);
    chk("fl_wr_ready", wr_ready, 0);
    chk("fl_rd_ready", rd_ready, 0);
    chk("fl_mem_en",   mem_en,   0);
    chk("fl_wr_ptr",   wr_ptr,   6);

    @(negedge CLK);
    flush = 1'b0;
    #1;
    chk("pf_wr_ready", wr_ready, 1);
    chk("pf_addr",     mem_addr, 0);
    chk("pf_wr_ptr",   wr_ptr,   0);
    chk("pf_rd_ready", rd_ready, 0);
    chk("pf_rd_valid", rd_valid, 0);

    for (int j = 1; j <= 20; j++) begin
      @(negedge CLK);
      #1;
      chk("f2_wr_ptr",   wr_ptr,   32'(j));
      chk("f2_addr",     mem_addr, 32'(j));
      chk("f2_rd_ready", rd_ready, 0);
    end

    // Asynchronous reset mid-frame at wr_ptr = 20
    #1;
    RST = 1'b1;
    #1;
    chk("ar_wr_ready", wr_ready, 0);
    chk("ar_rd_ready", rd_ready, 0);
    chk("ar_mem_en",   mem_en,   0);
    chk("ar_mem_we",   mem_we,   0);
    chk("ar_addr",     mem_addr, 0);
    chk("ar_wr_ptr",   wr_ptr,   0);

    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("ar_post_wr_ready", wr_ready, 1);
    chk("ar_post_addr",     mem_addr, 0);
    chk("ar_post_wr_ptr",   wr_ptr,   0);

    @(negedge CLK);
    wr_req = 1'b0; rd_req = 1'b0;
    @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
